corr_phase_search: RTL and testbench

- Sequencer that drives one `correlator` instance through a full code-phase sweep.
- For each phase it:
  - generates the reference code bit stream;
  - issues the capture pulses that bound one integration window;
  - reads the 16-bit match count through the correlator's 8-bit select mux.
- Tracks the best-matching phase and reports it with a threshold-based detect flag.
- Sits between the sampled input bit (`sig`, direct to the correlator) and the host/control logic that starts searches.

---
 rtl/corr_pkg.sv | 22 ++
 rtl/corr_code_gen.sv | 47 ++++
 rtl/corr_phase_search.sv | 172 +++++++++++++++++
 tb/tb_corr_phase_search.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared types and constants for the correlator phase-search sequencer.
package corr_pkg;

  localparam int CNT_W        = 16;
  localparam int RESULT_BYTES = 2;

  // Byte select encoding on the correlator result mux.
  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_INTEG,
    ST_CAPT,
    ST_RD_LO,
    ST_RD_HI,
    ST_CMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/corr_code_gen.sv
// Reference code generator: latched code word plus a wrapping chip index
// that can be loaded with a start phase and advanced one chip per cycle.
module corr_code_gen
  import corr_pkg::*;
#(
  parameter int CODE_LEN = 31,
  parameter int PHASE_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_code_i,
  input  logic [CODE_LEN-1:0] code_word_i,
  input  logic                load_phase_i,
  input  logic [PHASE_W-1:0]  phase_i,
  input  logic                advance_i,
  input  logic                enable_i,
  output logic                code_bit_o
);

  localparam int                 PAD_W     = 1 << PHASE_W;
  localparam logic [PHASE_W-1:0] LAST_CHIP = PHASE_W'(CODE_LEN - 1);

  logic [CODE_LEN-1:0] code_q;
  logic [PHASE_W-1:0]  chip_q;
  logic [PAD_W-1:0]    code_pad;

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
      chip_q <= '0;
    end else begin
      if (load_code_i) begin
        code_q <= code_word_i;
      end
      if (load_phase_i) begin
        chip_q <= phase_i;
      end else if (advance_i) begin
        chip_q <= (chip_q == LAST_CHIP) ? '0 : chip_q + 1'b1;
      end
    end
  end

  // Zero-padded to a power of two so every index value selects a real bit.
  assign code_pad   = PAD_W'(code_q);
  assign code_bit_o = enable_i & code_pad[chip_q];

endmodule

// File: rtl/corr_phase_search.sv
// Sweeps every code phase through an external correlator, integrating INT_LEN
// chips per phase, and reports the best-matching phase and a detect flag.
//
// state    | meaning
// IDLE     | waiting for start; results held
// PRIME    | capture pulse restarts correlator counters; first chip compared
// INTEG    | remaining INT_LEN-1 chips of the window
// CAPT     | capture pulse latches the window's match count
// RD_LO    | read result low byte
// RD_HI    | read result high byte
// CMP      | update best phase/count; next phase or finish
// DONE     | done pulse; detect flag registered
module corr_phase_search
  import corr_pkg::*;
#(
  parameter int CODE_LEN = 31,
  parameter int PHASE_W  = 5,
  parameter int INT_LEN  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code_word,
  input  logic [CNT_W-1:0]    threshold,
  output logic                corr_code,
  output logic                corr_capture,
  output logic                corr_select,
  input  logic [7:0]          corr_result,
  output logic                busy,
  output logic                done,
  output logic [PHASE_W-1:0]  best_phase,
  output logic [CNT_W-1:0]    best_count,
  output logic                detected
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CODE_LEN - 1);
  localparam logic [15:0]        WIN_LOAD   = 16'(INT_LEN - 1);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] best_phase_q, best_phase_d;
  logic [15:0]        win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   best_count_q, best_count_d;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic               detected_q, detected_d;
  logic               load_code;
  logic               load_phase;
  logic               chip_advance;
  logic               chip_enable;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    best_phase_d = best_phase_q;
    best_count_d = best_count_q;
    thr_d        = thr_q;
    detected_d   = detected_q;
    load_code    = 1'b0;
    chip_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_code    = 1'b1;
          thr_d        = threshold;
          phase_d      = '0;
          best_phase_d = '0;
          best_count_d = '0;
          detected_d   = 1'b0;
          state_d      = ST_PRIME;
        end
      end
      ST_PRIME: begin
        chip_advance = 1'b1;
        win_d        = WIN_LOAD;
        state_d      = ST_INTEG;
      end
      ST_INTEG: begin
        chip_advance = 1'b1;
        if (win_q == 16'd1) begin
          state_d = ST_CAPT;
        end else begin
          win_d = win_q - 16'd1;
        end
      end
      ST_CAPT: begin
        state_d = ST_RD_LO;
      end
      ST_RD_LO: begin
        cnt_d[7:0] = corr_result;
        state_d    = ST_RD_HI;
      end
      ST_RD_HI: begin
        cnt_d[15:8] = corr_result;
        state_d     = ST_CMP;
      end
      ST_CMP: begin
        // Strict compare: on a tie the earlier phase is kept.
        if (cnt_q > best_count_q) begin
          best_count_d = cnt_q;
          best_phase_d = phase_q;
        end
        if (phase_q == LAST_PHASE) begin
          state_d = ST_DONE;
        end else begin
          phase_d = phase_q + 1'b1;
          state_d = ST_PRIME;
        end
      end
      ST_DONE: begin
        detected_d = (best_count_q > thr_q);
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      best_phase_q <= '0;
      best_count_q <= '0;
      thr_q        <= '0;
      detected_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      best_phase_q <= best_phase_d;
      best_count_q <= best_count_d;
      thr_q        <= thr_d;
      detected_q   <= detected_d;
    end
  end

  // Chip index is loaded as PRIME is entered so PRIME compares chip[phase].
  assign load_phase  = (state_d == ST_PRIME);
  assign chip_enable = (state_q == ST_PRIME) || (state_q == ST_INTEG) ||
                       (state_q == ST_CAPT);

  corr_code_gen #(
    .CODE_LEN (CODE_LEN),
    .PHASE_W  (PHASE_W)
  ) u_code_gen (
    .clk          (clk),
    .rst          (rst),
    .load_code_i  (load_code),
    .code_word_i  (code_word),
    .load_phase_i (load_phase),
    .phase_i      (phase_d),
    .advance_i    (chip_advance),
    .enable_i     (chip_enable),
    .code_bit_o   (corr_code)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign corr_capture = (state_q == ST_PRIME) || (state_q == ST_CAPT);
  assign corr_select  = (state_q == ST_RD_HI) ? SEL_HI : SEL_LO;
  assign best_phase   = best_phase_q;
  assign best_count   = best_count_q;
  assign detected     = detected_q;

endmodule

// File: tb/tb_corr_phase_search.sv
// Bench for corr_phase_search with a behavioural correlator and a window-sum
// reference model of the phase sweep.
module tb_corr_phase_search;

  localparam int L     = 7;
  localparam int PW    = 3;
  localparam int IL    = 16;
  localparam int PER   = IL + 4;
  localparam int SWEEP = L * PER + 1;

  localparam int M_SHIFT = 0;
  localparam int M_ZERO  = 1;
  localparam int M_TIE   = 2;
  localparam int M_RAND  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [L-1:0]  code_word;
  logic [15:0]   threshold;
  logic          corr_code, corr_capture, corr_select;
  logic [7:0]    corr_result;
  logic          busy, done, detected;
  logic [PW-1:0] best_phase;
  logic [15:0]   best_count;
  logic          sig;

  int checks   = 0;
  int failures = 0;
  int tcyc     = 0;
  int s0       = 0;
  bit active   = 1'b0;
  bit sig_arr[0:255];
  logic [15:0] acc, res;
  int exp_cnt[L];
  int exp_best_p, exp_best_c;
  int cap_q[$];
  int sel_q[$];
  int done_cyc, done_cnt;
  logic busy1, det1;
  logic [15:0] bc1;

  corr_phase_search #(
    .CODE_LEN (L),
    .PHASE_W  (PW),
    .INT_LEN  (IL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .code_word    (code_word),
    .threshold    (threshold),
    .corr_code    (corr_code),
    .corr_capture (corr_capture),
    .corr_select  (corr_select),
    .corr_result  (corr_result),
    .busy         (busy),
    .done         (done),
    .best_phase   (best_phase),
    .best_count   (best_count),
    .detected     (detected)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  always_comb begin
    sig = 1'b0;
    if (active && (tcyc - s0) >= 0 && (tcyc - s0) < 256) sig = sig_arr[tcyc - s0];
  end

  // Correlator: counts matches; capture latches the count and restarts it
  // with the current cycle's compare.
  always @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      res <= '0;
    end else if (corr_capture) begin
      res <= acc;
      acc <= 16'(sig == corr_code);
    end else begin
      acc <= acc + 16'(sig == corr_code);
    end
  end
  assign corr_result = corr_select ? res[15:8] : res[7:0];

  function automatic void fill_sig(input int mode, input logic [L-1:0] cw);
    for (int c = 0; c < 256; c++) sig_arr[c] = (mode == M_RAND) ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int p = 0; p < L; p++) begin
      for (int j = 0; j < IL; j++) begin
        int c;
        c = p * PER + 1 + j;
        case (mode)
          M_SHIFT: sig_arr[c] = cw[(j + 3) % L];
          M_TIE:   sig_arr[c] = (p == 2 || p == 5) ? cw[(p + j) % L] : ~cw[(p + j) % L];
          default: ;
        endcase
      end
    end
  endfunction

  // Window for phase p: cycles p*PER+1 .. p*PER+IL, chip (p+j) mod L.
  function automatic void model(input logic [L-1:0] cw);
    exp_best_p = 0;
    exp_best_c = 0;
    for (int p = 0; p < L; p++) begin
      exp_cnt[p] = 0;
      for (int j = 0; j < IL; j++)
        if (cw[(p + j) % L] == sig_arr[p * PER + 1 + j]) exp_cnt[p]++;
      if (exp_cnt[p] > exp_best_c) begin
        exp_best_c = exp_cnt[p];
        exp_best_p = p;
      end
    end
  endfunction

  task automatic run_sweep(input logic [L-1:0] cw, input logic [15:0] thr, input int restart_at);
    cap_q.delete();
    sel_q.delete();
    done_cyc = -1;
    done_cnt = 0;
    @(negedge clk);
    code_word = cw;
    threshold = thr;
    start     = 1'b1;
    s0        = tcyc;
    active    = 1'b1;
    for (int k = 1; k <= SWEEP + 4; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (k == restart_at) begin
        code_word = ~cw;
        threshold = 16'd0;
      end
      if (k == 1) begin
        busy1 = busy;
        bc1   = best_count;
        det1  = detected;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (corr_capture) cap_q.push_back(k);
      if (corr_select) sel_q.push_back(k);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, corr_capture, corr_select, corr_code, detected} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, corr_capture, corr_select, corr_code, detected});
    end
    checks++;
    if (best_phase !== '0 || best_count !== '0) begin
      failures++;
      $display("FAIL reset_results: got phase %0d count %0d expected 0 0", best_phase, best_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shift();
    logic [L-1:0] cw;
    int errs;
    cw = 7'b1011100;
    fill_sig(M_SHIFT, cw);
    model(cw);
    run_sweep(cw, 16'd12, 0);
    checks++;
    if (done_cyc != SWEEP || done_cnt != 1) begin
      failures++;
      $display("FAIL shift_done: got cycle %0d count %0d expected cycle %0d count 1", done_cyc, done_cnt, SWEEP);
    end
    checks++;
    if (busy1 !== 1'b1) begin
      failures++;
      $display("FAIL shift_busy: got %b expected 1", busy1);
    end
    checks++;
    if (best_phase !== 3'd3 || best_count !== 16'd16) begin
      failures++;
      $display("FAIL shift_best: got phase %0d count %0d expected 3 16", best_phase, best_count);
    end
    checks++;
    if (best_count !== 16'(exp_best_c) || detected !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL shift_hold: got count %0d det %b busy %b expected %0d 1 0", best_count, detected, busy, exp_best_c);
    end
    errs = 0;
    if (cap_q.size() != 2 * L) errs++;
    else
      for (int p = 0; p < L; p++)
        if (cap_q[2*p] != p * PER + 1 || cap_q[2*p+1] != p * PER + 1 + IL) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL capture_pulses: got %0d pulses %0d bad expected %0d pulses 0 bad", cap_q.size(), errs, 2 * L);
    end
    errs = 0;
    if (sel_q.size() != L) errs++;
    else
      for (int p = 0; p < L; p++)
        if (sel_q[p] != p * PER + IL + 3) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL select_seq: got %0d highs %0d bad expected %0d highs 0 bad", sel_q.size(), errs, L);
    end
  endtask

  task automatic test_zero();
    logic [L-1:0] cw;
    cw = 7'b1011100;
    fill_sig(M_ZERO, cw);
    model(cw);
    run_sweep(cw, 16'd16, 0);
    checks++;
    if (bc1 !== 16'd0 || det1 !== 1'b0) begin
      failures++;
      $display("FAIL zero_clear_at_start: got count %0d det %b expected 0 0", bc1, det1);
    end
    checks++;
    if (best_phase !== 3'd0 || best_count !== 16'(exp_best_c) || best_count !== 16'd8) begin
      failures++;
      $display("FAIL zero_best: got phase %0d count %0d expected 0 %0d", best_phase, best_count, exp_best_c);
    end
    checks++;
    if (detected !== 1'b0) begin
      failures++;
      $display("FAIL zero_detect: got %b expected 0", detected);
    end
  endtask

  task automatic test_tie();
    logic [L-1:0] cw;
    cw = 7'b1011100;
    fill_sig(M_TIE, cw);
    model(cw);
    run_sweep(cw, 16'd15, 0);
    checks++;
    if (best_phase !== 3'd2 || best_count !== 16'd16 || detected !== 1'b1) begin
      failures++;
      $display("FAIL tie_best: got phase %0d count %0d det %b expected 2 16 1", best_phase, best_count, detected);
    end
  endtask

  task automatic test_random();
    logic [L-1:0] cw;
    logic [15:0] thr;
    for (int it = 0; it < 4; it++) begin
      cw = L'($urandom);
      fill_sig(M_RAND, cw);
      model(cw);
      case (it)
        0:       thr = 16'(exp_best_c);
        1:       thr = 16'(exp_best_c - 1);
        default: thr = 16'($urandom_range(0, IL));
      endcase
      run_sweep(cw, thr, 0);
      checks++;
      if (best_phase !== PW'(exp_best_p) || best_count !== 16'(exp_best_c) ||
          detected !== (16'(exp_best_c) > thr) || done_cyc != SWEEP) begin
        failures++;
        $display("FAIL random_%0d: got phase %0d count %0d det %b done@%0d expected %0d %0d %b %0d",
                 it, best_phase, best_count, detected, done_cyc, exp_best_p, exp_best_c,
                 16'(exp_best_c) > thr, SWEEP);
      end
    end
  endtask

  task automatic test_busy_start();
    logic [L-1:0] cw;
    int restarts[2];
    cw = 7'b1011100;
    restarts[0] = 40;
    restarts[1] = SWEEP;
    for (int r = 0; r < 2; r++) begin
      fill_sig(M_SHIFT, cw);
      model(cw);
      run_sweep(cw, 16'd12, restarts[r]);
      checks++;
      if (done_cyc != SWEEP || done_cnt != 1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_start_%0d: got done@%0d count %0d busy %b expected %0d 1 0",
                 r, done_cyc, done_cnt, busy, SWEEP);
      end
      checks++;
      if (best_phase !== PW'(exp_best_p) || best_count !== 16'(exp_best_c) || detected !== 1'b1) begin
        failures++;
        $display("FAIL busy_start_res_%0d: got phase %0d count %0d det %b expected %0d %0d 1",
                 r, best_phase, best_count, detected, exp_best_p, exp_best_c);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [L-1:0] cw;
    int pre;
    cw = 7'b1011100;
    fill_sig(M_SHIFT, cw);
    model(cw);
    pre = (exp_cnt[1] > exp_cnt[0]) ? exp_cnt[1] : exp_cnt[0];
    @(negedge clk);
    code_word = cw;
    threshold = 16'd12;
    start     = 1'b1;
    s0        = tcyc;
    active    = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || best_count !== 16'(pre)) begin
      failures++;
      $display("FAIL mid_live: got busy %b count %0d expected 1 %0d", busy, best_count, pre);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, corr_capture, corr_select, corr_code, detected} !== 6'b0 ||
        best_count !== '0 || best_phase !== '0) begin
      failures++;
      $display("FAIL mid_reset: got ctrl %b count %0d phase %0d expected 000000 0 0",
               {busy, done, corr_capture, corr_select, corr_code, detected}, best_count, best_phase);
    end
    rst = 1'b0;
    run_sweep(cw, 16'd12, 0);
    checks++;
    if (done_cyc != SWEEP || best_phase !== PW'(exp_best_p) || best_count !== 16'(exp_best_c) ||
        detected !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_rerun: got done@%0d phase %0d count %0d det %b expected %0d %0d %0d 1",
               done_cyc, best_phase, best_count, detected, SWEEP, exp_best_p, exp_best_c);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    code_word = '0;
    threshold = '0;
    test_reset();
    test_shift();
    test_zero();
    test_tie();
    test_random();
    test_busy_start();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
